// File: rtl/multicycle_maindec.sv
// Multi-cycle LEGv8 main decoder: an FSM steps each instruction through FETCH/DECODE/EXEC/MEM/WB (3-5 cycles).
// Memory backpressure via mem_ready stalls FETCH/MEM; a bounded wait or an illegal opcode parks it in a sticky FAULT.
module multicycle_maindec #(
   parameter int OP_W    = 11,
   parameter int TIMEOUT = 8,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [OP_W-1:0]  Op,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic             Reg2Loc,
   output logic             ALUSrc,
   output logic             MemtoReg,
   output logic [1:0]       ALUOp,
   output logic             RegWrite,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             Branch,
   output logic             instr_done,
   output logic             fault,
   output logic [1:0]       fault_code,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
   } state_t;

   typedef struct packed {
      logic       reg2loc;
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic [1:0] alu_op;
   } dec_t;

   localparam int WC_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   state_t          state;
   dec_t            lat;
   dec_t            dec;
   logic            legal;
   logic [10:0]     opc;
   logic [WC_W-1:0] wait_cnt;
   logic            wait_last;

   assign opc = Op[OP_W-1:OP_W-11];

   always_comb begin
      dec   = '0;
      legal = 1'b1;
      casez (opc)
         11'b111_1100_0010: dec = 9'b0_1_1_1_1_0_0_00;
         11'b111_1100_0000: dec = 9'b1_1_0_0_0_1_0_00;
         11'b101_1010_0???: dec = 9'b1_0_0_0_0_0_1_01;
         11'b100_0101_1000,
         11'b110_0101_1000,
         11'b100_0101_0000,
         11'b101_0101_0000: dec = 9'b0_0_0_1_0_0_0_10;
         default:           legal = 1'b0;
      endcase
   end

   // wait_cnt counts the low cycles already seen, so the TIMEOUT-th low cycle is the one at TIMEOUT-1
   assign wait_last = (TIMEOUT != 0) && (wait_cnt == WC_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         lat        <= '0;
         retired    <= '0;
         fault      <= 1'b0;
         fault_code <= 2'b00;
         wait_cnt   <= '0;
      end else begin
         if (instr_done)
            retired <= retired + 1'b1;
         case (state)
            S_IDLE: begin
               state    <= S_FETCH;
               wait_cnt <= '0;
            end
            S_FETCH: begin
               if (mem_ready) begin
                  state <= S_DECODE;
               end else if (wait_last) begin
                  state      <= S_FAULT;
                  fault      <= 1'b1;
                  fault_code <= 2'b10;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_DECODE: begin
               lat <= legal ? dec : '0;
               if (legal) begin
                  state <= S_EXEC;
               end else begin
                  state      <= S_FAULT;
                  fault      <= 1'b1;
                  fault_code <= 2'b01;
               end
            end
            S_EXEC: begin
               wait_cnt <= '0;
               if (lat.branch)
                  state <= S_FETCH;
               else if (lat.mem_read || lat.mem_write)
                  state <= S_MEM;
               else
                  state <= S_WB;
            end
            S_MEM: begin
               if (mem_ready) begin
                  state    <= lat.mem_read ? S_WB : S_FETCH;
                  wait_cnt <= '0;
               end else if (wait_last) begin
                  state      <= S_FAULT;
                  fault      <= 1'b1;
                  fault_code <= 2'b11;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_WB: begin
               state    <= S_FETCH;
               wait_cnt <= '0;
            end
            S_FAULT: state <= S_FAULT;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign mem_req    = (state == S_FETCH) || (state == S_MEM);
   assign IRWrite    = (state == S_FETCH) && mem_ready;
   assign PCWrite    = IRWrite;
   assign Reg2Loc    = lat.reg2loc;
   assign ALUSrc     = lat.alu_src;
   assign MemtoReg   = lat.mem_to_reg;
   assign ALUOp      = lat.alu_op;
   assign RegWrite   = (state == S_WB) && lat.reg_write;
   assign MemRead    = (state == S_MEM) && lat.mem_read;
   assign MemWrite   = (state == S_MEM) && lat.mem_write;
   assign Branch     = (state == S_EXEC) && lat.branch;
   assign instr_done = ((state == S_EXEC) && lat.branch)
                     || ((state == S_MEM) && mem_ready && !lat.mem_read)
                     || (state == S_WB);

endmodule

// File: tb/tb_multicycle_maindec.sv
// Instruction-level timeline model of the multi-cycle decoder with random waits, opcodes and don't-care inputs.
module tb_multicycle_maindec;
   localparam int TO = 4;
   localparam int CW = 2;

   localparam logic [10:0] LDUR = 11'b111_1100_0010;
   localparam logic [10:0] STUR = 11'b111_1100_0000;
   localparam logic [10:0] CBZ0 = 11'b101_1010_0000;
   localparam logic [10:0] ADD  = 11'b100_0101_1000;
   localparam logic [10:0] SUB  = 11'b110_0101_1000;
   localparam logic [10:0] ANDI = 11'b100_0101_0000;
   localparam logic [10:0] ORR  = 11'b101_0101_0000;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [10:0]   Op = '0;
   logic          mem_ready = 1'b0;
   logic          mem_req, IRWrite, PCWrite, Reg2Loc, ALUSrc, MemtoReg;
   logic [1:0]    ALUOp;
   logic          RegWrite, MemRead, MemWrite, Branch, instr_done, fault;
   logic [1:0]    fault_code;
   logic [CW-1:0] retired;

   always #5 clk = ~clk;

   multicycle_maindec #(.OP_W(11), .TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
      .mem_req(mem_req), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .ALUOp(ALUOp),
      .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
      .instr_done(instr_done), .fault(fault), .fault_code(fault_code), .retired(retired)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // model state: {reg2loc, alusrc, memtoreg, aluop}, retired count, sticky fault
   logic [4:0] m_stat = '0;
   int         m_ret = 0;
   logic       m_fault = 1'b0;
   logic [1:0] m_code = 2'b00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   function automatic logic [10:0] rop();
      return 11'($urandom);
   endfunction

   // {legal, reg2loc, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop}
   function automatic logic [9:0] ref_dec(input logic [10:0] o);
      if (o == LDUR)               return 10'b1_0_1_1_1_1_0_0_00;
      if (o == STUR)               return 10'b1_1_1_0_0_0_1_0_00;
      if (o[10:3] == CBZ0[10:3])   return 10'b1_1_0_0_0_0_0_1_01;
      if (o == ADD || o == SUB || o == ANDI || o == ORR)
                                   return 10'b1_0_0_0_1_0_0_0_10;
      return 10'b0;
   endfunction

   function automatic logic [31:0] expv(input logic req, input logic irw, input logic rw,
                                        input logic mr, input logic mw, input logic br,
                                        input logic done);
      logic [CW-1:0] r;
      r = CW'(m_ret);
      return 32'({req, irw, irw, m_stat[4:2], m_stat[1:0], rw, mr, mw, br, done,
                  m_fault, m_code, r});
   endfunction

   function automatic logic [31:0] obsv();
      return 32'({mem_req, IRWrite, PCWrite, Reg2Loc, ALUSrc, MemtoReg, ALUOp,
                  RegWrite, MemRead, MemWrite, Branch, instr_done, fault, fault_code, retired});
   endfunction

   task automatic drive(input logic rst, input logic rdy, input logic [10:0] op);
      @(negedge clk);
      reset = rst;
      mem_ready = rdy;
      Op = op;
      #1;
   endtask

   task automatic step(input string tag, input logic rst, input logic rdy,
                       input logic [10:0] op, input logic [31:0] exp);
      drive(rst, rdy, op);
      chk(tag, obsv(), exp);
   endtask

   task automatic model_reset();
      m_stat = '0; m_ret = 0; m_fault = 1'b0; m_code = 2'b00;
   endtask

   task automatic bump();
      m_ret = (m_ret + 1) % (1 << CW);
   endtask

   // two reset cycles then the IDLE cycle; the DUT is in FETCH afterwards
   task automatic do_reset();
      drive(1'b1, rb(), rop());
      model_reset();
      step("reset_hold", 1'b1, rb(), rop(), expv(0, 0, 0, 0, 0, 0, 0));
      step("idle", 1'b0, rb(), rop(), expv(0, 0, 0, 0, 0, 0, 0));
   endtask

   task automatic fault_hold(input int n);
      for (int k = 0; k < n; k++)
         step("fault_hold", 1'b0, rb(), rop(), expv(0, 0, 0, 0, 0, 0, 0));
   endtask

   // one instruction from its first FETCH cycle: fw/mw low cycles before ready, optional reset in MEM cycle rst_at
   task automatic run_instr(input string nm, input logic [10:0] op, input int fw,
                            input int mw, input int rst_at);
      logic [9:0] d;
      logic       rdy;
      d = ref_dec(op);
      for (int i = 0; i < fw; i++) begin
         step({nm, "/fetch_wait"}, 1'b0, 1'b0, rop(), expv(1, 0, 0, 0, 0, 0, 0));
         if (TO != 0 && i == TO - 1) begin
            m_fault = 1'b1; m_code = 2'b10;
            return;
         end
      end
      step({nm, "/fetch"}, 1'b0, 1'b1, rop(), expv(1, 1, 0, 0, 0, 0, 0));
      step({nm, "/decode"}, 1'b0, rb(), op, expv(0, 0, 0, 0, 0, 0, 0));
      if (!d[9]) begin
         m_fault = 1'b1; m_code = 2'b01; m_stat = '0;
         return;
      end
      m_stat = {d[8:6], d[1:0]};
      if (d[2]) begin
         step({nm, "/exec_cbz"}, 1'b0, rb(), rop(), expv(0, 0, 0, 0, 0, 1, 1));
         bump();
         return;
      end
      step({nm, "/exec"}, 1'b0, rb(), rop(), expv(0, 0, 0, 0, 0, 0, 0));
      if (d[4] || d[3]) begin
         for (int j = 0; j <= mw; j++) begin
            rdy = (j == mw);
            if (j == rst_at) begin
               step({nm, "/mem_rst"}, 1'b1, rdy, rop(), expv(1, 0, 0, d[4], d[3], 0, rdy & d[3]));
               model_reset();
               step({nm, "/idle_after_rst"}, 1'b0, rb(), rop(), expv(0, 0, 0, 0, 0, 0, 0));
               return;
            end
            step({nm, "/mem"}, 1'b0, rdy, rop(), expv(1, 0, 0, d[4], d[3], 0, rdy & d[3]));
            if (!rdy && TO != 0 && j == TO - 1) begin
               m_fault = 1'b1; m_code = 2'b11;
               return;
            end
         end
         if (d[3]) begin
            bump();
            return;
         end
      end
      step({nm, "/wb"}, 1'b0, rb(), rop(), expv(0, 0, 1, 0, 0, 0, 1));
      bump();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [10:0] op;
      int          sel, fw, mw, ra;

      do_reset();
      run_instr("ldur", LDUR, 0, 0, -1);
      run_instr("stur", STUR, 0, 3, -1);
      run_instr("cbz", 11'b101_1010_0101, 0, 0, -1);
      run_instr("orr", ORR, 0, 0, -1);
      run_instr("illegal", 11'h000, 0, 0, -1);
      fault_hold(20);
      do_reset();
      run_instr("fetch_to", ADD, TO, 0, -1);
      fault_hold(3);
      do_reset();
      run_instr("fetch_late", ADD, TO - 1, 0, -1);
      run_instr("mem_to", STUR, 0, TO, -1);
      fault_hold(3);
      do_reset();
      for (int k = 0; k < 5; k++)
         run_instr("wrap", ADD, 0, 0, -1);
      run_instr("ldur_rst", LDUR, 0, 3, 1);

      for (int n = 0; n < 300; n++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0, 8:    op = LDUR;
            1, 9:    op = STUR;
            2:       op = CBZ0 | 11'($urandom_range(0, 7));
            3:       op = ADD;
            4:       op = SUB;
            5:       op = ANDI;
            6:       op = ORR;
            default: op = rop();
         endcase
         fw = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, TO - 1);
         mw = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, TO - 1);
         ra = ($urandom_range(0, 19) == 0) ? $urandom_range(0, mw) : -1;
         run_instr("rand", op, fw, mw, ra);
         if (m_fault) begin
            fault_hold($urandom_range(1, 5));
            do_reset();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/multicycle_maindec.md
Name: multicycle_maindec

Overview:
- Multi-cycle successor to the single-cycle main decoder for the LEGv8 core (LDUR, STUR, CBZ, ADD/SUB/AND/ORR).
- A Moore FSM sequences each instruction over 3-5 cycles and waits on a memory ready handshake.
- Flags an illegal opcode or a memory timeout with a sticky fault, and counts retired instructions.

Parameters:
- OP_W, 11, opcode width; the decoder matches on Op[OP_W-1:OP_W-11].
- TIMEOUT, 8, number of consecutive wait cycles with mem_ready low before fault; 0 disables the timeout.
- CNT_W, 8, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous reset, active-high.
- Op  in  OP_W  opcode field from the instruction register; sampled in DECODE only.
- mem_ready  in  1  memory completes the request this cycle.
- mem_req  out  1  memory request, active in FETCH and MEM.
- IRWrite  out  1  load the instruction register; FETCH cycle with mem_ready=1.
- PCWrite  out  1  PC+4 update; same cycle as IRWrite.
- Reg2Loc, ALUSrc, MemtoReg  out  1 each  static flags from the latched decode.
- ALUOp  out  2  static ALU op from the latched decode.
- RegWrite, MemRead, MemWrite, Branch  out  1 each  state-qualified strobes.
- instr_done  out  1  one-cycle pulse on the final cycle of an instruction.
- fault  out  1  sticky fault.
- fault_code  out  2  01 illegal op, 10 fetch timeout, 11 mem timeout, 00 none.
- retired  out  CNT_W  retired-instruction count; wraps modulo 2^CNT_W.

Behaviour:
- Reset: synchronous. State goes to IDLE. Latched flags, retired, fault, fault_code and the wait counter are cleared. All outputs are 0 in IDLE. Reset overrides every state, including FAULT and a pending memory wait.
- Decode table (Reg2Loc ALUSrc MemtoReg RegWrite MemRead MemWrite Branch ALUOp):
  - LDUR 111_1100_0010 = 0 1 1 1 1 0 0 00
  - STUR 111_1100_0000 = 1 1 0 0 0 1 0 00
  - CBZ 101_1010_0xxx = 1 0 0 0 0 0 1 01
  - ADD 100_0101_1000, SUB 110_0101_1000, AND 100_0101_0000, ORR 101_0101_0000 = 0 0 0 1 0 0 0 10
  - Anything else is illegal.
- Latching: the decode result is latched at the end of DECODE. Static outputs reflect the latch and hold until the next DECODE. The RegWrite/MemRead/MemWrite/Branch table bits gate the strobes; they are never driven directly.
- IDLE -> FETCH, unconditionally, on the next cycle.
- FETCH:
  - mem_req=1.
  - mem_ready=1: IRWrite=1 and PCWrite=1, go to DECODE.
  - Otherwise stay.
- DECODE: latch Op. Illegal -> FAULT with code 01. Legal -> EXEC.
- EXEC:
  - CBZ: Branch=1 for exactly this cycle, instr_done=1, go to FETCH.
  - R-type: go to WB.
  - LDUR/STUR: go to MEM.
- MEM:
  - mem_req=1.
  - LDUR: MemRead=1 throughout.
  - STUR: MemWrite=1 throughout.
  - mem_ready=1: LDUR goes to WB; STUR asserts instr_done and goes to FETCH.
- WB: RegWrite=1 for one cycle, instr_done=1, go to FETCH.
- FAULT:
  - fault=1 and fault_code hold until reset.
  - All strobes, mem_req and instr_done are 0.
  - Op and mem_ready are ignored.
- Latency, with mem_ready high on the first request cycle:
  - CBZ 3 cycles; STUR 4; R-type 4; LDUR 5.
  - Each memory wait cycle adds 1.
- Timeout:
  - The wait counter clears on entry to FETCH or MEM.
  - It increments on each cycle in those states with mem_ready=0.
  - On the TIMEOUT-th consecutive low cycle, go to FAULT with code 10 (FETCH) or 11 (MEM).
  - mem_ready=1 on any earlier cycle proceeds normally. The cycle after the last low cycle is never reached as a wait if ready arrives there.
  - TIMEOUT=0 waits forever.
- retired increments by 1 on every instr_done and wraps from 2^CNT_W-1 to 0. It is unaffected by fault.
- Ignored inputs: mem_ready outside FETCH/MEM; Op outside DECODE.

Test Plan:
1. Reset for 2 cycles, then LDUR with mem_ready=1 constantly.
   - Required states: IDLE, FETCH, DECODE, EXEC, MEM, WB.
   - IRWrite=PCWrite=1 in FETCH only; MemRead=1 in MEM only; RegWrite=1 and instr_done=1 in WB only.
   - Static flags = 0 1 1 x x x x 00; retired=1 after WB.
2. STUR with mem_ready low for 3 MEM cycles, then high.
   - MemWrite=mem_req=1 for 4 cycles; RegWrite never 1.
   - instr_done on the 4th MEM cycle, then FETCH; Reg2Loc=1, ALUOp=00.
3. CBZ (11'b101_1010_0101) followed by ORR.
   - Branch=1 for 1 cycle in EXEC with ALUOp=01, instr_done in the same cycle.
   - ORR then completes in 4 cycles with ALUOp=10; retired=2.
4. Op=11'h000 in DECODE.
   - From the next cycle: fault=1, fault_code=01, mem_req=0, all strobes 0.
   - Holds for 20 cycles regardless of Op/mem_ready; reset then clears to IDLE with fault=0.
5. TIMEOUT=4.
   - mem_ready low for 4 cycles in FETCH -> fault_code=10.
   - Rerun with mem_ready high on the 4th cycle -> IRWrite=1, no fault.
   - Repeat in MEM -> fault_code=11.
6. CNT_W=2: run 5 R-type instructions -> retired reads 1, 2, 3, 0, 1. Assert reset in the second MEM cycle of an LDUR -> next cycle IDLE, all outputs 0, retired=0, no RegWrite.
